// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with forwarding match, trace port and retire counter
module mem_wb_reg #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          mem_valid_i,
  input  logic [DW-1:0] mem_pc_i,
  input  logic [DW-1:0] mem_wD_i,
  input  logic [RW-1:0] mem_wR_i,
  input  logic          mem_rf_we_i,
  input  logic [RW-1:0] id_rs1_i,
  input  logic [RW-1:0] id_rs2_i,
  output logic          wb_valid_o,
  output logic [DW-1:0] wb_wD_o,
  output logic [RW-1:0] wb_wR_o,
  output logic          wb_rf_we_o,
  output logic          fwd_rs1_o,
  output logic          fwd_rs2_o,
  output logic          debug_wb_have_inst_o,
  output logic [DW-1:0] debug_wb_pc_o,
  output logic          debug_wb_ena_o,
  output logic [RW-1:0] debug_wb_reg_o,
  output logic [DW-1:0] debug_wb_value_o,
  output logic [CW-1:0] retire_cnt_o
);

  logic          valid_q, valid_d;
  logic          fresh_q, fresh_d;
  logic          we_q,    we_d;
  logic [DW-1:0] pc_q,    pc_d;
  logic [DW-1:0] wd_q,    wd_d;
  logic [RW-1:0] wr_q,    wr_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic load;
  logic rf_we;

  assign load = !flush_i && !stall_i;

  // Next-state selection: flush beats stall beats load; the counter only moves on a valid load
  always_comb begin
    valid_d = valid_q;
    fresh_d = fresh_q;
    we_d    = we_q;
    pc_d    = pc_q;
    wd_d    = wd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      valid_d = 1'b0;
      fresh_d = 1'b0;
      we_d    = 1'b0;
      pc_d    = '0;
      wd_d    = '0;
      wr_d    = '0;
    end else if (stall_i) begin
      // A held instruction must only be reported on the trace port once
      fresh_d = 1'b0;
    end else begin
      valid_d = mem_valid_i;
      fresh_d = mem_valid_i;
      we_d    = mem_rf_we_i & mem_valid_i;
      pc_d    = mem_pc_i;
      wd_d    = mem_wD_i;
      wr_d    = mem_wR_i;
    end
    if (load && mem_valid_i && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // WB state registers, cleared immediately by the asynchronous reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
      we_q    <= 1'b0;
      pc_q    <= '0;
      wd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      fresh_q <= fresh_d;
      we_q    <= we_d;
      pc_q    <= pc_d;
      wd_q    <= wd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Writes to x0 never reach the register file; the data is still presented
  assign rf_we = we_q & valid_q & (wr_q != '0);

  assign wb_valid_o           = valid_q;
  assign wb_wD_o              = wd_q;
  assign wb_wR_o              = wr_q;
  assign wb_rf_we_o           = rf_we;
  assign fwd_rs1_o            = rf_we & (wr_q == id_rs1_i);
  assign fwd_rs2_o            = rf_we & (wr_q == id_rs2_i);
  assign debug_wb_have_inst_o = valid_q & fresh_q;
  assign debug_wb_pc_o        = pc_q;
  assign debug_wb_ena_o       = rf_we & fresh_q;
  assign debug_wb_reg_o       = wr_q;
  assign debug_wb_value_o     = wd_q;
  assign retire_cnt_o         = cnt_q;

endmodule

// File: tb/tb_mem_wb_reg.sv
// tb/tb_mem_wb_reg.sv - randomized and directed bench for mem_wb_reg against a reference model
module tb_mem_wb_reg;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, mem_valid, mem_we;
  logic [31:0] mem_pc, mem_wd;
  logic [4:0]  mem_wr, id_rs1, id_rs2;

  logic        wb_valid, wb_rf_we, fwd1, fwd2, have, ena;
  logic [31:0] wb_wd, dbg_pc, dbg_val, cnt;
  logic [4:0]  wb_wr, dbg_reg;

  logic        s_valid, s_rf_we, s_fwd1, s_fwd2, s_have, s_ena;
  logic [31:0] s_wd, s_pc, s_val;
  logic [4:0]  s_wr, s_reg;
  logic [2:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_valid, m_fresh, m_we;
  logic [31:0] m_pc, m_wd;
  logic [4:0]  m_wr;
  longint      m_cnt;
  int          m_cnt3;

  mem_wb_reg #(.DW(32), .RW(5), .CW(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush),
    .mem_valid_i(mem_valid), .mem_pc_i(mem_pc), .mem_wD_i(mem_wd), .mem_wR_i(mem_wr),
    .mem_rf_we_i(mem_we), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .wb_valid_o(wb_valid), .wb_wD_o(wb_wd), .wb_wR_o(wb_wr), .wb_rf_we_o(wb_rf_we),
    .fwd_rs1_o(fwd1), .fwd_rs2_o(fwd2), .debug_wb_have_inst_o(have),
    .debug_wb_pc_o(dbg_pc), .debug_wb_ena_o(ena), .debug_wb_reg_o(dbg_reg),
    .debug_wb_value_o(dbg_val), .retire_cnt_o(cnt)
  );

  mem_wb_reg #(.DW(32), .RW(5), .CW(3)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush),
    .mem_valid_i(mem_valid), .mem_pc_i(mem_pc), .mem_wD_i(mem_wd), .mem_wR_i(mem_wr),
    .mem_rf_we_i(mem_we), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .wb_valid_o(s_valid), .wb_wD_o(s_wd), .wb_wR_o(s_wr), .wb_rf_we_o(s_rf_we),
    .fwd_rs1_o(s_fwd1), .fwd_rs2_o(s_fwd2), .debug_wb_have_inst_o(s_have),
    .debug_wb_pc_o(s_pc), .debug_wb_ena_o(s_ena), .debug_wb_reg_o(s_reg),
    .debug_wb_value_o(s_val), .retire_cnt_o(s_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    m_valid = 0; m_fresh = 0; m_we = 0;
    m_pc = 0; m_wd = 0; m_wr = 0;
    m_cnt = 0; m_cnt3 = 0;
  endtask

  // one clock: the model applies the pipeline rules to the inputs seen at the edge
  task automatic tick();
    @(posedge clk);
    if (flush) begin
      m_valid = 0; m_fresh = 0; m_we = 0; m_pc = 0; m_wd = 0; m_wr = 0;
    end else if (stall) begin
      m_fresh = 0;
    end else begin
      m_valid = mem_valid;
      m_fresh = mem_valid;
      m_we    = mem_we && mem_valid;
      m_pc    = mem_pc;
      m_wd    = mem_wd;
      m_wr    = mem_wr;
      if (mem_valid) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt3 < 7) m_cnt3 = m_cnt3 + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(bit st, bit fl, bit v, logic [31:0] pc, logic [31:0] wd, logic [4:0] wr, bit we);
    stall = st; flush = fl; mem_valid = v; mem_pc = pc; mem_wd = wd; mem_wr = wr; mem_we = we;
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    id_rs1 = 0; id_rs2 = 0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    drive(0, 0, 1, 32'h100, 32'hDEAD, 5, 1);
    id_rs1 = 5; id_rs2 = 5;
    tick();
    total++;
    if (wb_wd !== 32'hDEAD || wb_rf_we !== 1'b1 || cnt !== 32'd1) begin
      bad++;
      $display("FAIL reset_preload: wd=%h we=%b cnt=%0d exp wd=dead we=1 cnt=1", wb_wd, wb_rf_we, cnt);
    end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    total++;
    if ({wb_valid, wb_wd, wb_wr, wb_rf_we, fwd1, fwd2, have, dbg_pc, ena, dbg_reg, dbg_val, cnt} !== '0) begin
      bad++;
      $display("FAIL reset_async: valid=%b wd=%h wr=%0d we=%b fwd=%b%b have=%b pc=%h ena=%b cnt=%0d exp all 0",
               wb_valid, wb_wd, wb_wr, wb_rf_we, fwd1, fwd2, have, dbg_pc, ena, cnt);
    end
    total++;
    if (s_cnt !== 3'd0 || s_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async_small: cnt=%0d valid=%b exp 0 0", s_cnt, s_valid);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load();
    drive(0, 0, 1, 32'h200, 32'h1234, 3, 1);
    tick();
    total++;
    if (wb_rf_we !== 1'b1 || wb_wr !== 5'd3 || have !== 1'b1 || cnt !== 32'd1 || wb_wd !== 32'h1234) begin
      bad++;
      $display("FAIL load: we=%b wr=%0d have=%b cnt=%0d wd=%h exp 1 3 1 1 1234", wb_rf_we, wb_wr, have, cnt, wb_wd);
    end
  endtask

  task automatic test_stall();
    drive(1, 0, 1, 32'h300, 32'h5555, 9, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (wb_wd !== 32'h1234 || wb_rf_we !== 1'b1 || have !== 1'b0 || cnt !== 32'd1 || ena !== 1'b0) begin
        bad++;
        $display("FAIL stall[%0d]: wd=%h we=%b have=%b ena=%b cnt=%0d exp 1234 1 0 0 1", i, wb_wd, wb_rf_we, have, ena, cnt);
      end
    end
  endtask

  task automatic test_flush();
    drive(1, 1, 1, 32'h400, 32'h7777, 4, 1);
    tick();
    total++;
    if (wb_valid !== 1'b0 || wb_rf_we !== 1'b0 || cnt !== 32'd1 || wb_wd !== 32'd0) begin
      bad++;
      $display("FAIL flush: valid=%b we=%b cnt=%0d wd=%h exp 0 0 1 0", wb_valid, wb_rf_we, cnt, wb_wd);
    end
  endtask

  task automatic test_x0();
    drive(0, 0, 1, 32'h500, 32'hFFFF, 0, 1);
    id_rs1 = 0;
    tick();
    total++;
    if (wb_rf_we !== 1'b0 || ena !== 1'b0 || have !== 1'b1 || fwd1 !== 1'b0 || wb_wd !== 32'hFFFF) begin
      bad++;
      $display("FAIL x0: we=%b ena=%b have=%b fwd1=%b wd=%h exp 0 0 1 0 ffff", wb_rf_we, ena, have, fwd1, wb_wd);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    id_rs2 = 7;
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 1, 32'h600 + 4 * i, 32'hA000 + i, 7, 1);
      tick();
      total++;
      if (s_cnt !== 3'((i + 1 > 7) ? 7 : i + 1)) begin
        bad++;
        $display("FAIL sat_cnt[%0d]: got %0d exp %0d", i, s_cnt, (i + 1 > 7) ? 7 : i + 1);
      end
    end
    total++;
    if (s_fwd2 !== 1'b1 || fwd2 !== 1'b1 || cnt !== 32'd9) begin
      bad++;
      $display("FAIL b2b_fwd: s_fwd2=%b fwd2=%b cnt=%0d exp 1 1 9", s_fwd2, fwd2, cnt);
    end
  endtask

  task automatic test_random();
    bit e_we;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
            $urandom, $urandom, 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      tick();
      e_we = m_valid && m_we && (m_wr != 0);
      total++;
      if (wb_valid !== m_valid || wb_wd !== m_wd || wb_wr !== m_wr || wb_rf_we !== e_we) begin
        bad++;
        $display("FAIL rand_wb[%0d]: valid=%b wd=%h wr=%0d we=%b exp %b %h %0d %b",
                 i, wb_valid, wb_wd, wb_wr, wb_rf_we, m_valid, m_wd, m_wr, e_we);
      end
      total++;
      if (fwd1 !== (e_we && m_wr == id_rs1) || fwd2 !== (e_we && m_wr == id_rs2)) begin
        bad++;
        $display("FAIL rand_fwd[%0d]: fwd=%b%b exp %b%b", i, fwd1, fwd2,
                 e_we && m_wr == id_rs1, e_we && m_wr == id_rs2);
      end
      total++;
      if (have !== (m_valid && m_fresh) || ena !== (e_we && m_fresh) || dbg_pc !== m_pc ||
          dbg_reg !== m_wr || dbg_val !== m_wd) begin
        bad++;
        $display("FAIL rand_trace[%0d]: have=%b ena=%b pc=%h reg=%0d val=%h exp %b %b %h %0d %h", i,
                 have, ena, dbg_pc, dbg_reg, dbg_val, m_valid && m_fresh, e_we && m_fresh, m_pc, m_wr, m_wd);
      end
      total++;
      if (cnt !== 32'(m_cnt) || s_cnt !== 3'(m_cnt3)) begin
        bad++;
        $display("FAIL rand_cnt[%0d]: cnt=%0d small=%0d exp %0d %0d", i, cnt, s_cnt, m_cnt, m_cnt3);
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_x0();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
